// File: rtl/reg_bank_lockable.sv
// Configuration storage array: DEPTH x DATA_W registers with byte-strobed writes,
// sticky per-register write locks, 1-cycle registered reads and optional write->read bypass.
module reg_bank_lockable #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 32,
  parameter int                ADDR_W    = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                BYPASS    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_en,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                lock_en,
  input  logic                read_en,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                werr,
  output logic                rerr
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  lock;

  logic              w_in_range;
  logic              r_in_range;
  logic              w_ok;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_next;

  // When DEPTH fills the whole address space every address is legal.
  generate
    if ((1 << ADDR_W) <= DEPTH) begin : g_full_range
      assign w_in_range = 1'b1;
      assign r_in_range = 1'b1;
    end else begin : g_part_range
      assign w_in_range = int'(waddr) < DEPTH;
      assign r_in_range = int'(raddr) < DEPTH;
    end
  endgenerate

  assign w_ok = write_en && w_in_range && !lock[waddr];

  always_comb begin
    merged = mem[waddr];
    for (int b = 0; b < NB; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  always_comb begin
    rd_next = '0;
    if (r_in_range) begin
      rd_next = (BYPASS && w_ok && (waddr == raddr)) ? merged : mem[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
      lock <= '0;
    end else if (w_ok) begin
      mem[waddr] <= merged;
      if (lock_en) lock[waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      werr   <= 1'b0;
      rerr   <= 1'b0;
    end else begin
      werr   <= write_en && !w_ok;
      rvalid <= read_en;
      rerr   <= read_en && !r_in_range;
      if (read_en) rdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_reg_bank_lockable.sv
// Bench for reg_bank_lockable: three builds (default, no bypass, DEPTH=20) share stimulus;
// a per-build reference model feeds a scoreboard queue, plus a directed vector table.
module tb_reg_bank_lockable;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_en = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        lock_en = 1'b0;
  logic        read_en = 1'b0;
  logic [4:0]  raddr = '0;

  logic [31:0] rdata0, rdata1, rdata2;
  logic        rvalid0, rvalid1, rvalid2;
  logic        werr0, werr1, werr2;
  logic        rerr0, rerr1, rerr2;

  always #5 clk = ~clk;

  reg_bank_lockable u_main (
    .clk(clk), .rst(rst), .write_en(write_en), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .lock_en(lock_en), .read_en(read_en), .raddr(raddr),
    .rdata(rdata0), .rvalid(rvalid0), .werr(werr0), .rerr(rerr0));

  reg_bank_lockable #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst(rst), .write_en(write_en), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .lock_en(lock_en), .read_en(read_en), .raddr(raddr),
    .rdata(rdata1), .rvalid(rvalid1), .werr(werr1), .rerr(rerr1));

  reg_bank_lockable #(.DEPTH(20)) u_small (
    .clk(clk), .rst(rst), .write_en(write_en), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .lock_en(lock_en), .read_en(read_en), .raddr(raddr),
    .rdata(rdata2), .rvalid(rvalid2), .werr(werr2), .rerr(rerr2));

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        rvalid;
    logic        werr;
    logic        rerr;
  } exp_t;

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    bit          le;
    bit          re;
    logic [4:0]  ra;
    logic [31:0] x_rdata;
    bit          x_rvalid;
    bit          x_werr;
    bit          x_rerr;
  } vec_t;

  int checks = 0;
  int failures = 0;

  exp_t        sbq[$];
  logic [31:0] m_regs [3][32];
  bit          m_lock [3][32];
  logic [31:0] m_rdata [3];
  int          dep [3] = '{32, 32, 20};
  bit          byp [3] = '{1'b1, 1'b0, 1'b1};

  bit cov_addr [32];
  bit cov_strb [16];
  int cov_lockwrite = 0;
  int cov_coll = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic get_out(input int k, output logic [31:0] d, output logic v, output logic we,
                         output logic re);
    case (k)
      0:       begin d = rdata0; v = rvalid0; we = werr0; re = rerr0; end
      1:       begin d = rdata1; v = rvalid1; we = werr1; re = rerr1; end
      default: begin d = rdata2; v = rvalid2; we = werr2; re = rerr2; end
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_rdata[k] = '0;
      for (int a = 0; a < 32; a++) begin
        m_regs[k][a] = '0;
        m_lock[k][a] = 1'b0;
      end
    end
  endtask

  // Reference behaviour for build k given the currently driven inputs.
  task automatic model_step(input int k);
    exp_t        e;
    bit          inr, wok;
    logic [31:0] mrg;
    inr = int'(waddr) < dep[k];
    wok = write_en && inr && !m_lock[k][waddr];
    mrg = m_regs[k][waddr];
    for (int b = 0; b < 4; b++) if (wstrb[b]) mrg[8*b +: 8] = wdata[8*b +: 8];
    e.inst   = k;
    e.werr   = write_en && !wok;
    e.rvalid = read_en;
    e.rerr   = read_en && (int'(raddr) >= dep[k]);
    if (read_en) begin
      if (int'(raddr) >= dep[k])                 m_rdata[k] = '0;
      else if (byp[k] && wok && waddr == raddr)  m_rdata[k] = mrg;
      else                                       m_rdata[k] = m_regs[k][raddr];
    end
    e.rdata = m_rdata[k];
    if (k == 0 && write_en && inr && m_lock[k][waddr]) cov_lockwrite++;
    if (k == 0 && write_en && read_en && waddr == raddr) cov_coll++;
    if (wok) begin
      m_regs[k][waddr] = mrg;
      if (lock_en) m_lock[k][waddr] = 1'b1;
    end
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t        e;
    logic [31:0] d;
    logic        v, we, re;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      get_out(e.inst, d, v, we, re);
      chk($sformatf("sb%0d_rdata", e.inst), d, e.rdata);
      chk($sformatf("sb%0d_rvalid", e.inst), 32'(v), 32'(e.rvalid));
      chk($sformatf("sb%0d_werr", e.inst), 32'(we), 32'(e.werr));
      chk($sformatf("sb%0d_rerr", e.inst), 32'(re), 32'(e.rerr));
    end
  endtask

  task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input bit le, input bit re, input logic [4:0] ra);
    @(negedge clk);
    write_en = we; waddr = wa; wdata = wd; wstrb = ws; lock_en = le;
    read_en = re; raddr = ra;
    if (we) begin
      cov_addr[wa] = 1'b1;
      cov_strb[ws] = 1'b1;
    end
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    #1;
    sb_check();
  endtask

  // Reset asserted asynchronously while a write/read is being presented.
  task automatic do_reset();
    logic [31:0] d;
    logic        v, we, re;
    @(negedge clk);
    write_en = 1'b1; waddr = 5'd5; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; lock_en = 1'b1;
    read_en = 1'b1; raddr = 5'd5;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      get_out(k, d, v, we, re);
      chk($sformatf("rst%0d_rdata", k), d, 32'h0);
      chk($sformatf("rst%0d_flags", k), {29'd0, v, we, re}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    write_en = 1'b0; lock_en = 1'b0; read_en = 1'b0; wstrb = '0;
    model_reset();
  endtask

  function automatic vec_t mk(bit we, logic [4:0] wa, logic [31:0] wd, logic [3:0] ws, bit le,
                              bit re, logic [4:0] ra, logic [31:0] xd, bit xv, bit xw, bit xr);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ws = ws; v.le = le; v.re = re; v.ra = ra;
    v.x_rdata = xd; v.x_rvalid = xv; v.x_werr = xw; v.x_rerr = xr;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    // Expected outputs of the default build one edge after each row is presented.
    tbl[0]  = mk(0, 5'd0, 32'h0,          4'h0, 0, 1, 5'd0,  32'h0000_0000, 1, 0, 0);
    tbl[1]  = mk(0, 5'd0, 32'h0,          4'h0, 0, 1, 5'd15, 32'h0000_0000, 1, 0, 0);
    tbl[2]  = mk(0, 5'd0, 32'h0,          4'h0, 0, 1, 5'd31, 32'h0000_0000, 1, 0, 0);
    tbl[3]  = mk(0, 5'd0, 32'h0,          4'h0, 0, 0, 5'd0,  32'h0000_0000, 0, 0, 0);
    tbl[4]  = mk(1, 5'd5, 32'hAABB_CCDD,  4'hF, 0, 0, 5'd0,  32'h0000_0000, 0, 0, 0);
    tbl[5]  = mk(1, 5'd5, 32'h1122_3344,  4'h5, 0, 0, 5'd0,  32'h0000_0000, 0, 0, 0);
    tbl[6]  = mk(0, 5'd0, 32'h0,          4'h0, 0, 1, 5'd5,  32'hAA22_CC44, 1, 0, 0);
    tbl[7]  = mk(1, 5'd7, 32'hDEAD_BEEF,  4'hF, 0, 1, 5'd7,  32'hDEAD_BEEF, 1, 0, 0);
    tbl[8]  = mk(1, 5'd3, 32'h1234_5678,  4'hF, 1, 0, 5'd0,  32'hDEAD_BEEF, 0, 0, 0);
    tbl[9]  = mk(1, 5'd3, 32'hFFFF_FFFF,  4'hF, 0, 0, 5'd0,  32'hDEAD_BEEF, 0, 1, 0);
    tbl[10] = mk(0, 5'd0, 32'h0,          4'h0, 0, 1, 5'd3,  32'h1234_5678, 1, 0, 0);
    tbl[11] = mk(1, 5'd3, 32'hFFFF_FFFF,  4'hF, 1, 1, 5'd3,  32'h1234_5678, 1, 1, 0);
    tbl[12] = mk(1, 5'd9, 32'h0000_0055,  4'h0, 0, 0, 5'd0,  32'h1234_5678, 0, 0, 0);
    tbl[13] = mk(1, 5'd9, 32'h0000_0066,  4'h0, 1, 0, 5'd0,  32'h1234_5678, 0, 0, 0);
    tbl[14] = mk(1, 5'd9, 32'h0000_0001,  4'hF, 0, 0, 5'd0,  32'h1234_5678, 0, 1, 0);
    tbl[15] = mk(0, 5'd0, 32'h0,          4'h0, 0, 1, 5'd9,  32'h0000_0000, 1, 0, 0);

    model_reset();
    do_reset();

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ws, tbl[i].le, tbl[i].re, tbl[i].ra);
      chk($sformatf("vec%0d_rdata", i), rdata0, tbl[i].x_rdata);
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid0), 32'(tbl[i].x_rvalid));
      chk($sformatf("vec%0d_werr", i), 32'(werr0), 32'(tbl[i].x_werr));
      chk($sformatf("vec%0d_rerr", i), 32'(rerr0), 32'(tbl[i].x_rerr));
    end

    // Same-address collision: bypass build forwards, non-bypass build returns old data.
    drive(1, 5'd11, 32'hCAFE_F00D, 4'hF, 0, 1, 5'd11);
    chk("coll_bypass", rdata0, 32'hCAFE_F00D);
    chk("coll_nobypass", rdata1, 32'h0000_0000);
    drive(0, 5'd0, 32'h0, 4'h0, 0, 1, 5'd11);
    chk("nobypass_later", rdata1, 32'hCAFE_F00D);

    // Out-of-range on the 20-deep build.
    drive(1, 5'd25, 32'hFFFF_FFFF, 4'hF, 1, 0, 5'd0);
    chk("oor_werr_small", 32'(werr2), 32'd1);
    chk("oor_werr_main", 32'(werr0), 32'd0);
    drive(0, 5'd0, 32'h0, 4'h0, 0, 1, 5'd25);
    chk("oor_rdata", rdata2, 32'h0);
    chk("oor_rvalid", 32'(rvalid2), 32'd1);
    chk("oor_rerr", 32'(rerr2), 32'd1);
    chk("oor_werr_clear", 32'(werr2), 32'd0);
    for (int a = 0; a < 20; a++) drive(0, 5'd0, 32'h0, 4'h0, 0, 1, 5'(a));
    chk("oor_rerr_clear", 32'(rerr2), 32'd0);

    // Reset clears locks and discards the write presented during reset.
    do_reset();
    drive(0, 5'd0, 32'h0, 4'h0, 0, 1, 5'd5);
    chk("rst_discard", rdata0, 32'h0);
    drive(1, 5'd3, 32'hFFFF_FFFF, 4'hF, 0, 0, 5'd0);
    chk("unlock_werr", 32'(werr0), 32'd0);
    drive(0, 5'd0, 32'h0, 4'h0, 0, 1, 5'd3);
    chk("unlock_rdata", rdata0, 32'hFFFF_FFFF);

    // Random soak against the model.
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] wa, ra;
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(bit'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 15) == 0), bit'($urandom_range(0, 1)), ra);
    end

    begin
      int na, ns;
      na = 0; ns = 0;
      foreach (cov_addr[a]) if (cov_addr[a]) na++;
      foreach (cov_strb[s]) if (cov_strb[s]) ns++;
      $display("coverage addr_bins=%0d/32 strb_bins=%0d/16 lockwrites=%0d collisions=%0d",
               na, ns, cov_lockwrite, cov_coll);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_lockable.md
Name: reg_bank_lockable

Overview:
Parametrised successor to the team's 32x32 register bank. It provides one write port and one read port over DEPTH registers of DATA_W bits, with:
- byte-strobed writes
- registered reads with a valid flag
- a configurable write-to-read bypass
- a per-register write-lock latched until reset
- error flags for out-of-range and locked accesses

It sits behind the control/status decode as the configuration storage array.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
DEPTH, 32, number of registers; need not be a power of two.
ADDR_W, $clog2(DEPTH), address width.
RESET_VAL, 0, value loaded into every register on reset (DATA_W bits).
BYPASS, 1, 1 = a same-cycle read of the address being written returns the new data; 0 = it returns the old data.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
write_en  input  1  write request this cycle.
waddr  input  ADDR_W  write address.
wdata  input  DATA_W  write data.
wstrb  input  DATA_W/8  byte enables; bit i enables wdata[8i+7:8i].
lock_en  input  1  qualified by write_en; locks waddr after this write.
read_en  input  1  read request this cycle.
raddr  input  ADDR_W  read address.
rdata  output  DATA_W  registered read data.
rvalid  output  1  rdata is valid this cycle.
werr  output  1  one-cycle pulse: the write was rejected.
rerr  output  1  one-cycle pulse: the read was out of range.

Behaviour:
- Reset (async assert, released synchronously by the system):
  - all registers = RESET_VAL; all lock bits = 0
  - rdata = 0, rvalid = 0, werr = 0, rerr = 0
  - reset mid-transaction discards the transaction; no partial byte update survives.
- Write, when write_en = 1 at a clk edge:
  - waddr >= DEPTH: no state change; werr = 1 next cycle; lock_en is ignored.
  - lock[waddr] = 1: no state change; werr = 1 next cycle.
  - Otherwise: each byte with wstrb[i] = 1 is updated from wdata; other bytes hold. werr = 0.
  - If lock_en = 1, lock[waddr] is set at the same edge; the write itself takes effect, including when wstrb = 0.
  - wstrb = 0 with lock_en = 0 is a legal no-op with no error.
- Read:
  - read_en = 1 at edge N gives rvalid = 1 and rdata at edge N+1 (latency 1).
  - read_en = 0 gives rvalid = 0; rdata holds its last value.
  - raddr >= DEPTH: rdata = 0, rvalid = 1, rerr = 1 for one cycle.
  - Back-to-back reads every cycle give full throughput, one result per cycle.
- Simultaneous read and write of the same address, write accepted:
  - BYPASS = 1: rdata = byte-merged new value (strobed bytes from wdata, the rest from the stored value).
  - BYPASS = 0: rdata = pre-write value.
  - A rejected write (locked or out of range) never forwards; rdata = stored value.
- Different addresses in the same cycle are independent.
- Lock bits are sticky; only rst clears them. Reads of locked registers are unaffected.
- werr and rerr are registered, deassert the next cycle unless re-triggered, and are independent of each other.
- The bank has no state machine beyond the per-register lock bits and the registered read stage.

Test Plan:
- Reset then read: rst 1→0, then read addrs 0, 15, 31 → rdata = 0x00000000 each (RESET_VAL = 0), rvalid one cycle after each read_en, werr = rerr = 0.
- Byte strobes: write addr 5 = 0xAABBCCDD with wstrb = 0xF, then wdata = 0x11223344 with wstrb = 0x5 → read addr 5 = 0xAA22CC44.
- Bypass: BYPASS = 1, stored addr 7 = 0x0, write 0xDEADBEEF (wstrb = 0xF) plus read addr 7 in the same cycle → rdata = 0xDEADBEEF. BYPASS = 0 build, same stimulus → rdata = 0x00000000, then a later read = 0xDEADBEEF.
- Lock: write addr 3 = 0x12345678 with lock_en = 1 → werr = 0; then write addr 3 = 0xFFFFFFFF → werr = 1 for exactly one cycle and read addr 3 = 0x12345678. After rst, the write of 0xFFFFFFFF succeeds and reads back.
- Out of range (DEPTH = 20, ADDR_W = 5):
  - write addr 25 → werr = 1, no register changes (sweep-read 0..19 unchanged).
  - read addr 25 → rdata = 0, rvalid = 1, rerr = 1.
- Random soak: 2000 cycles of random write/read/lock/strobe against the scoreboard model → zero mismatches. Coverage bins: all addresses, every wstrb value, lock-then-write, same-address collision.
